// File: rtl/sensor_rx_buf.sv
// Sensor burst receiver with a DEPTH-word register-file capture buffer and CPU read-back.
// Optional: SENSOR_RX_AUTORESTART_EN makes a read of the last word in FULL act as a clear.
module sensor_rx_buf #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sctrl_en,
  input  logic          sctrl_clear,
  input  logic [AW-1:0] sctrl_addr,
  output logic [DW-1:0] sctrl_rdata,
  output logic          sctrl_interrupt,
  output logic [AW:0]   sctrl_count,
  output logic          sensor_en,
  input  logic          sensor_ready,
  input  logic [DW-1:0] sensor_out_0,
  input  logic [DW-1:0] sensor_out_1,
  input  logic [DW-1:0] sensor_out_2,
  input  logic [DW-1:0] sensor_out_3,
  input  logic [DW-1:0] sensor_out_4,
  input  logic [DW-1:0] sensor_out_5,
  input  logic [DW-1:0] sensor_out_6,
  input  logic [DW-1:0] sensor_out_7
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_FULL
  } state_t;

  state_t        r_state;
  logic [AW:0]   r_wptr;
  logic          r_sensor_en;
  logic          r_irq;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_buf [DEPTH];

  logic [DW-1:0] w_lane [8];
  logic          w_wr;
  logic [AW:0]   w_wptr_nxt;
  logic          w_full_nxt;
  logic          w_restart;

  assign w_lane[0] = sensor_out_0;
  assign w_lane[1] = sensor_out_1;
  assign w_lane[2] = sensor_out_2;
  assign w_lane[3] = sensor_out_3;
  assign w_lane[4] = sensor_out_4;
  assign w_lane[5] = sensor_out_5;
  assign w_lane[6] = sensor_out_6;
  assign w_lane[7] = sensor_out_7;

  always_comb begin
    w_wr       = (r_state == S_ACQ) && sensor_ready && !sctrl_clear;
    w_wptr_nxt = r_wptr + (AW+1)'(8);
    w_full_nxt = (w_wptr_nxt == (AW+1)'(DEPTH));
`ifdef SENSOR_RX_AUTORESTART_EN
    w_restart  = (r_state == S_FULL) && (sctrl_addr == AW'(DEPTH-1));
`else
    w_restart  = 1'b0;
`endif
  end

  // Clear dominates every state, including a coincident capture strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_sensor_en <= 1'b0;
      r_irq       <= 1'b0;
    end else if (sctrl_clear) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_sensor_en <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sctrl_en) begin
            r_state     <= S_ACQ;
            r_sensor_en <= 1'b1;
          end
        end
        S_ACQ: begin
          if (sensor_ready) begin
            r_wptr <= w_wptr_nxt;
            if (w_full_nxt) begin
              r_state     <= S_FULL;
              r_sensor_en <= 1'b0;
              r_irq       <= 1'b1;
            end else if (!sctrl_en) begin
              r_state     <= S_IDLE;
              r_sensor_en <= 1'b0;
            end
          end else if (!sctrl_en) begin
            r_state     <= S_IDLE;
            r_sensor_en <= 1'b0;
          end
        end
        S_FULL: begin
          if (w_restart) begin
            r_wptr <= '0;
            r_irq  <= 1'b0;
            if (sctrl_en) begin
              r_state     <= S_ACQ;
              r_sensor_en <= 1'b1;
            end else begin
              r_state     <= S_IDLE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_sensor_en <= 1'b0;
        end
      endcase
    end
  end

  // wptr is always 8-aligned, so a burst fills the row whose upper index bits match it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (i[AW-1:3] == r_wptr[AW-1:3]) r_buf[i] <= w_lane[i[2:0]];
        end
      end
      r_rdata <= r_buf[sctrl_addr];
    end
  end

  assign sctrl_rdata     = r_rdata;
  assign sctrl_interrupt = r_irq;
  assign sctrl_count     = r_wptr;
  assign sensor_en       = r_sensor_en;

endmodule

// File: tb/tb_sensor_rx_buf.sv
// Directed bench for sensor_rx_buf: capture, fill, pause, clear priority, reset, autorestart.
module tb_sensor_rx_buf;

  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          sctrl_en;
  logic          sctrl_clear;
  logic [AW-1:0] sctrl_addr;
  logic [DW-1:0] sctrl_rdata;
  logic          sctrl_interrupt;
  logic [AW:0]   sctrl_count;
  logic          sensor_en;
  logic          sensor_ready;
  logic [DW-1:0] so [8];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  sensor_rx_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .sctrl_en        (sctrl_en),
    .sctrl_clear     (sctrl_clear),
    .sctrl_addr      (sctrl_addr),
    .sctrl_rdata     (sctrl_rdata),
    .sctrl_interrupt (sctrl_interrupt),
    .sctrl_count     (sctrl_count),
    .sensor_en       (sensor_en),
    .sensor_ready    (sensor_ready),
    .sensor_out_0    (so[0]),
    .sensor_out_1    (so[1]),
    .sensor_out_2    (so[2]),
    .sensor_out_3    (so[3]),
    .sensor_out_4    (so[4]),
    .sensor_out_5    (so[5]),
    .sensor_out_6    (so[6]),
    .sensor_out_7    (so[7])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_words(input logic [DW-1:0] base);
    for (int k = 0; k < 8; k++) so[k] = base + DW'(k);
  endtask

  // Drive one burst for one cycle; returns on the following negedge with ready low.
  task automatic burst(input logic [DW-1:0] base);
    set_words(base);
    sensor_ready = 1'b1;
    @(negedge clk);
    sensor_ready = 1'b0;
  endtask

  task automatic rd(input string tag, input int unsigned addr, input logic [DW-1:0] exp);
    sctrl_addr = AW'(addr);
    @(negedge clk);
    check(tag, 64'(sctrl_rdata), 64'(exp));
  endtask

  task automatic clear_pulse();
    sctrl_clear = 1'b1;
    @(negedge clk);
    sctrl_clear = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int b = 0; b < 8; b++) begin
      if (b == 7) check("fill_irq_before_last", 64'(sctrl_interrupt), 64'd0);
      set_words(base + DW'(8 * b));
      sensor_ready = 1'b1;
      @(negedge clk);
    end
    sensor_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sctrl_en = 1'b0; sctrl_clear = 1'b0; sctrl_addr = '0;
    sensor_ready = 1'b0; set_words('0);
    repeat (2) @(negedge clk);
    check("rst_sensor_en", 64'(sensor_en), 64'd0);
    check("rst_irq", 64'(sctrl_interrupt), 64'd0);
    check("rst_count", 64'(sctrl_count), 64'd0);
    check("rst_rdata", 64'(sctrl_rdata), 64'd0);
    rst = 1'b0;

    // Single burst
    sctrl_en = 1'b1;
    @(negedge clk);
    check("acq_sensor_en", 64'(sensor_en), 64'd1);
    burst(32'h1000_0000);
    check("single_count", 64'(sctrl_count), 64'd8);
    for (int a = 0; a < 8; a++) rd("single_rd", a, 32'h1000_0000 + 32'(a));
    rd("single_rd8", 8, 32'h0);

    // Clear beats a coincident ready at count 16
    burst(32'h1100_0000);
    check("cvr_pre_count", 64'(sctrl_count), 64'd16);
    set_words(32'hEEEE_0000);
    sensor_ready = 1'b1;
    sctrl_clear  = 1'b1;
    @(negedge clk);
    sensor_ready = 1'b0;
    sctrl_clear  = 1'b0;
    check("cvr_count", 64'(sctrl_count), 64'd0);
    check("cvr_idle_en", 64'(sensor_en), 64'd0);
    check("cvr_irq", 64'(sctrl_interrupt), 64'd0);
    rd("cvr_rd16", 16, 32'h0);
    rd("cvr_rd23", 23, 32'h0);
    rd("cvr_keep0", 0, 32'h1000_0000);

    // Fill, then a 9th strobe must not write
    clear_pulse();
    @(negedge clk);
    check("fill_en", 64'(sensor_en), 64'd1);
    fill(32'h0);
    check("fill_irq", 64'(sctrl_interrupt), 64'd1);
    check("fill_en_low", 64'(sensor_en), 64'd0);
    check("fill_count", 64'(sctrl_count), 64'd64);
    burst(32'hDEAD_0000);
    check("full_count_hold", 64'(sctrl_count), 64'd64);
    rd("full_rd0", 0, 32'h0);
    rd("full_rd9", 9, 32'd9);
    rd("full_rd62", 62, 32'd62);

    // Asynchronous reset while FULL
    #2 rst = 1'b1;
    sctrl_en = 1'b0;
    #1;
    check("arst_irq", 64'(sctrl_interrupt), 64'd0);
    check("arst_count", 64'(sctrl_count), 64'd0);
    check("arst_en", 64'(sensor_en), 64'd0);
    check("arst_rdata", 64'(sctrl_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd("arst_rd9", 9, 32'h0);
    rd("arst_rd62", 62, 32'h0);

    // Pause: en falls with the 2nd burst, which still lands
    sctrl_en = 1'b1;
    @(negedge clk);
    burst(32'h2000_0000);
    sctrl_en = 1'b0;
    burst(32'h2000_0008);
    check("pause_coinc_count", 64'(sctrl_count), 64'd16);
    for (int c = 0; c < 5; c++) begin
      check("pause_en", 64'(sensor_en), 64'd0);
      if (c == 2) begin
        set_words(32'hBAD0_0000);
        sensor_ready = 1'b1;
      end
      @(negedge clk);
      sensor_ready = 1'b0;
    end
    check("pause_count", 64'(sctrl_count), 64'd16);
    sctrl_en = 1'b1;
    @(negedge clk);
    check("resume_en", 64'(sensor_en), 64'd1);
    burst(32'h3000_0000);
    check("resume_count", 64'(sctrl_count), 64'd24);
    rd("pause_rd8", 8, 32'h2000_0008);
    rd("pause_rd16", 16, 32'h3000_0000);
    rd("pause_rd23", 23, 32'h3000_0007);
    rd("pause_rd24", 24, 32'h0);

    // Read of the last word while FULL
    clear_pulse();
    @(negedge clk);
    fill(32'h4000_0000);
    check("refill_irq", 64'(sctrl_interrupt), 64'd1);
    sctrl_addr = AW'(DEPTH - 1);
    @(negedge clk);
    check("last_rdata", 64'(sctrl_rdata), 64'h4000_003F);
`ifdef SENSOR_RX_AUTORESTART_EN
    check("ar_irq", 64'(sctrl_interrupt), 64'd0);
    check("ar_en", 64'(sensor_en), 64'd1);
    check("ar_count", 64'(sctrl_count), 64'd0);
`else
    check("noar_irq", 64'(sctrl_interrupt), 64'd1);
    check("noar_en", 64'(sensor_en), 64'd0);
    check("noar_count", 64'(sctrl_count), 64'd64);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sensor_rx_buf.md
# sensor_rx_buf

Sensor-side receiver and capture buffer for the 8-lane sensor interface. It asserts `sensor_en` to request data and captures one 8-word burst on each `sensor_ready` strobe into a 64-word register-file buffer. When the buffer is full it raises `sctrl_interrupt` and holds `sensor_en` low. It sits in the CPU clock domain behind the sensor-controller register slave, which reads captured words back by address.

## Interface

Parameters:

- `DW`, 32: sensor word width.
- `DEPTH`, 64: buffer depth in words. Must be a multiple of 8.
- `AW`, 6: read address width, log2(`DEPTH`).

Ports:

- `clk`  in  1  block clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sctrl_en`  in  1  acquisition enable (level).
- `sctrl_clear`  in  1  clear pulse (one cycle).
- `sctrl_addr`  in  AW  read word address.
- `sctrl_rdata`  out  DW  registered read data.
- `sctrl_interrupt`  out  1  buffer-full flag (level).
- `sctrl_count`  out  AW+1  number of words captured, 0..DEPTH.
- `sensor_en`  out  1  request to the sensor.
- `sensor_ready`  in  1  burst-valid strobe, one cycle per burst.
- `sensor_out_0` .. `sensor_out_7`  in  DW each  burst words 0..7.

## Operation

State machine with three states: IDLE, ACQ, FULL. Reset enters IDLE.

**IDLE**
- `sensor_en` = 0. `sensor_ready` is ignored.
- If `sctrl_en`=1 and `sctrl_clear`=0, go to ACQ.

**ACQ**
- `sensor_en` = 1.
- On `sensor_ready`=1, write `sensor_out_k` to `buf[wptr+k]` for k = 0..7, all in the same edge. Then `wptr` += 8.
- If the new `wptr` = DEPTH, go to FULL.
- If `sctrl_en`=0 (and no full transition), go to IDLE with `wptr` kept. This is a pause; re-enabling resumes at the same `wptr`.
- If `sctrl_en` falls in the same cycle as `sensor_ready`, the burst is still captured.

**FULL**
- `sensor_en` = 0. `sctrl_interrupt` = 1. `sensor_ready` is ignored and no buffer write occurs.

**Clear**
- `sctrl_clear`=1 in any state sets `wptr` = 0, clears `sctrl_interrupt` and goes to IDLE.
- Clear has priority over a coincident `sensor_ready`: that burst is discarded.
- Buffer contents are not erased by clear.

**Reads and count**
- `sctrl_rdata` ← `buf[sctrl_addr]` on every edge. Reads are non-destructive and allowed in any state.
- A read of the entry being written in the same cycle returns the old value.
- `sctrl_count` = `wptr`. It saturates at DEPTH and never wraps.

**Reset values**
- State IDLE, `wptr`=0, every buffer entry 0.
- Outputs: `sensor_en`=0, `sctrl_interrupt`=0, `sctrl_rdata`=0, `sctrl_count`=0.
- Reset asserted mid-burst aborts the capture immediately.

## Timing

- `sensor_en` and `sctrl_interrupt` are flops updated with the state register.
  - `sensor_en` rises on the edge that enters ACQ.
  - On the capture edge that fills the buffer, `sensor_en` falls and `sctrl_interrupt` rises on that same edge.
- Sensor data must be valid in the cycle where `sensor_ready`=1. Captured words are readable one cycle later.
- Read latency is 1 cycle from `sctrl_addr` to `sctrl_rdata`.
- Back-to-back `sensor_ready` in consecutive cycles captures two bursts.
- IDLE→ACQ costs 1 cycle after `sctrl_en` rises.

## Configuration

`SENSOR_RX_AUTORESTART_EN`:

- **Defined:** in FULL, a read with `sctrl_addr` = DEPTH-1 acts as an implicit clear.
  - That read returns the last word normally.
  - On the same edge `wptr` becomes 0 and `sctrl_interrupt` falls.
  - The state goes to ACQ if `sctrl_en`=1, otherwise to IDLE.
- **Undefined:** reads never change state. Only `sctrl_clear` or `rst` leaves FULL.

## Test plan

- **Single burst.** Reset, set `sctrl_en`=1, pulse `sensor_ready` with `sensor_out_k` = 0x1000_0000+k. Required: `sctrl_count`=8; reads at addresses 0..7 return 0x1000_0000..0x1000_0007 one cycle after each address; address 8 reads 0.
- **Fill.** Drive 8 bursts with word = 8·b+k. Required: `sctrl_interrupt`=1 and `sensor_en`=0 on the 8th capture edge; a 9th `sensor_ready` does not overwrite (address 0 still reads 0); `sctrl_count`=64.
- **Pause.** Capture 2 bursts, drop `sctrl_en` for 5 cycles, re-enable, capture 1 burst. Required: `sensor_en`=0 during the pause, `sensor_ready` during the pause is ignored, the third burst lands at addresses 16..23, `sctrl_count`=24.
- **Clear vs ready.** Assert `sctrl_clear` and `sensor_ready` in the same cycle while in ACQ with `sctrl_count`=16. Required: `sctrl_count`=0, state IDLE, addresses 16..23 unchanged (read 0).
- **Reset mid-operation.** Assert `rst` asynchronously in FULL. Required: all outputs 0 immediately and all entries read 0.
- **With `SENSOR_RX_AUTORESTART_EN`.** Fill with `sctrl_en`=1, then read address 63. Required: `sctrl_rdata` = last word, `sctrl_interrupt` falls and `sensor_en` rises on that edge, `sctrl_count`=0. Without the macro, the same read leaves `sctrl_interrupt`=1.
